// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths, MAC latency default and sequencer state encoding,
// so the MAC and its controller agree on widths and pipeline depth.
package cnn_pkg;
   localparam int CNN_DATA_WIDTH = 16;
   localparam int CNN_ACC_WIDTH  = 40;
   localparam int CNN_MAC_LAT    = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;
endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate acc_out = acc_in + a*b; result valid MAC_LAT cycles
// after valid_in (1 cycle if not PIPELINED). Pipeline advances only while en is high.
module mac_unit
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int ACC_WIDTH  = CNN_ACC_WIDTH,
   parameter int MAC_LAT    = CNN_MAC_LAT,
   parameter int PIPELINED  = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_en,
   input  logic                         i_valid,
   input  logic signed [DATA_WIDTH-1:0] i_a,
   input  logic signed [DATA_WIDTH-1:0] i_b,
   input  logic signed [ACC_WIDTH-1:0]  i_acc_in,
   output logic signed [ACC_WIDTH-1:0]  o_acc_out,
   output logic                         o_valid
);
   localparam int STAGES = (PIPELINED != 0) ? MAC_LAT : 1;

   logic signed [ACC_WIDTH-1:0] w_a_ext;
   logic signed [ACC_WIDTH-1:0] w_b_ext;
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic signed [ACC_WIDTH-1:0] r_acc [STAGES];
   logic        [STAGES-1:0]    r_vld;

   // Widen before multiplying so the product is not truncated to DATA_WIDTH.
   assign w_a_ext = i_a;
   assign w_b_ext = i_b;
   assign w_sum   = i_acc_in + w_a_ext * w_b_ext;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_acc[i] <= '0;
         end
         r_vld <= '0;
      end else if (i_en) begin
         r_acc[0] <= w_sum;
         r_vld[0] <= i_valid;
         for (int i = 1; i < STAGES; i++) begin
            r_acc[i] <= r_acc[i-1];
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   assign o_acc_out = r_acc[STAGES-1];
   assign o_valid   = r_vld[STAGES-1];
endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one MAC through an N-term signed dot product; 2+MAC_LAT cycles per term.
// Result is held in DONE until res_ready; start is ignored outside IDLE.
module mac_seq_ctrl
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int ACC_WIDTH  = CNN_ACC_WIDTH,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10,
   parameter int MAC_LAT    = CNN_MAC_LAT
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  logic        [LEN_WIDTH-1:0]  i_len,
   input  logic        [ADDR_WIDTH-1:0] i_a_base,
   input  logic        [ADDR_WIDTH-1:0] i_b_base,
   input  logic signed [ACC_WIDTH-1:0]  i_bias,
   output logic                         o_busy,
   output logic                         o_rd_en,
   output logic        [ADDR_WIDTH-1:0] o_a_addr,
   output logic        [ADDR_WIDTH-1:0] o_b_addr,
   input  logic signed [DATA_WIDTH-1:0] i_a_rdata,
   input  logic signed [DATA_WIDTH-1:0] i_b_rdata,
   output logic                         o_mac_en,
   output logic                         o_mac_valid,
   output logic signed [DATA_WIDTH-1:0] o_mac_a,
   output logic signed [DATA_WIDTH-1:0] o_mac_b,
   output logic signed [ACC_WIDTH-1:0]  o_mac_acc_in,
   input  logic signed [ACC_WIDTH-1:0]  i_mac_acc_out,
   output logic                         o_res_valid,
   input  logic                         i_res_ready,
   output logic signed [ACC_WIDTH-1:0]  o_result
);
   localparam int WCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAC_LAT - 1);

   seq_state_t                  r_state;
   logic        [LEN_WIDTH-1:0]  r_len;
   logic        [LEN_WIDTH-1:0]  r_idx;
   logic        [ADDR_WIDTH-1:0] r_a_base;
   logic        [ADDR_WIDTH-1:0] r_b_base;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic        [WCNT_W-1:0]     r_wcnt;

   logic                         r_busy;
   logic                         r_rd_en;
   logic        [ADDR_WIDTH-1:0] r_a_addr;
   logic        [ADDR_WIDTH-1:0] r_b_addr;
   logic                         r_mac_en;
   logic                         r_mac_valid;
   logic signed [ACC_WIDTH-1:0]  r_mac_acc_in;
   logic                         r_res_valid;
   logic signed [ACC_WIDTH-1:0]  r_result;

   logic                         w_last_term;
   logic        [LEN_WIDTH-1:0]  w_idx_nxt;

   assign w_last_term = (r_idx == r_len - LEN_WIDTH'(1));
   assign w_idx_nxt   = r_idx + LEN_WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_idx        <= '0;
         r_a_base     <= '0;
         r_b_base     <= '0;
         r_acc        <= '0;
         r_wcnt       <= '0;
         r_busy       <= 1'b0;
         r_rd_en      <= 1'b0;
         r_a_addr     <= '0;
         r_b_addr     <= '0;
         r_mac_en     <= 1'b0;
         r_mac_valid  <= 1'b0;
         r_mac_acc_in <= '0;
         r_res_valid  <= 1'b0;
         r_result     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_len    <= i_len;
                  r_a_base <= i_a_base;
                  r_b_base <= i_b_base;
                  r_acc    <= i_bias;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  if (i_len == '0) begin
                     r_state     <= ST_DONE;
                     r_res_valid <= 1'b1;
                     r_result    <= i_bias;
                  end else begin
                     r_state  <= ST_FETCH;
                     r_rd_en  <= 1'b1;
                     r_a_addr <= i_a_base;
                     r_b_addr <= i_b_base;
                  end
               end
            end
            ST_FETCH: begin
               r_rd_en      <= 1'b0;
               r_mac_en     <= 1'b1;
               r_mac_valid  <= 1'b1;
               r_mac_acc_in <= r_acc;
               r_state      <= ST_ISSUE;
            end
            ST_ISSUE: begin
               r_mac_valid <= 1'b0;
               r_wcnt      <= '0;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // MAC keeps clocking (en=1) with acc_in held until the sum emerges.
               if (r_wcnt == WCNT_LAST) begin
                  r_acc        <= i_mac_acc_out;
                  r_mac_en     <= 1'b0;
                  r_mac_acc_in <= '0;
                  if (w_last_term) begin
                     r_state     <= ST_DONE;
                     r_res_valid <= 1'b1;
                     r_result    <= i_mac_acc_out;
                  end else begin
                     r_idx    <= w_idx_nxt;
                     r_state  <= ST_FETCH;
                     r_rd_en  <= 1'b1;
                     r_a_addr <= r_a_base + ADDR_WIDTH'(w_idx_nxt);
                     r_b_addr <= r_b_base + ADDR_WIDTH'(w_idx_nxt);
                  end
               end else begin
                  r_wcnt <= r_wcnt + WCNT_W'(1);
               end
            end
            ST_DONE: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operand data arrives from memory during ISSUE, so it is steered rather than registered.
   assign o_mac_a      = (r_state == ST_ISSUE) ? i_a_rdata : '0;
   assign o_mac_b      = (r_state == ST_ISSUE) ? i_b_rdata : '0;
   assign o_busy       = r_busy;
   assign o_rd_en      = r_rd_en;
   assign o_a_addr     = r_a_addr;
   assign o_b_addr     = r_b_addr;
   assign o_mac_en     = r_mac_en;
   assign o_mac_valid  = r_mac_valid;
   assign o_mac_acc_in = r_mac_acc_in;
   assign o_res_valid  = r_res_valid;
   assign o_result     = r_result;
endmodule
